// File: rtl/carryskip_sub_seq32_if.sv
// Operand and result handshake bundle for the iterative carry-skip subtractor.
// master = producer/consumer side, slave = the subtractor.
interface carryskip_sub_seq32_if #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
);
    localparam int NG = WIDTH / BLOCK;
    localparam int SW = $clog2(NG + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic [SW-1:0]    skip_cnt;

    modport master (
        output in_valid, x, y, bin, out_ready,
        input  in_ready, out_valid, d, bout, skip_cnt
    );

    modport slave (
        input  in_valid, x, y, bin, out_ready,
        output in_ready, out_valid, d, bout, skip_cnt
    );
endinterface

// File: rtl/carryskip_sub_seq32.sv
// Iterative carry-skip subtract d = x - y - bin, one BLOCK-bit group per cycle; out_valid rises NG edges after accept.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so nothing is accepted while busy.
module carryskip_sub_seq32 #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic                clk,
    input  logic                rst,
    carryskip_sub_seq32_if.slave io
);
    localparam int NG = WIDTH / BLOCK;
    localparam int SW = $clog2(NG + 1);
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [GW-1:0] LAST_G = GW'(NG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic [GW-1:0]    g_q, g_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic [SW-1:0]    skip_cnt_q, skip_cnt_d;

    logic [BLOCK-1:0] x_grp, y_grp, p_grp;
    logic [BLOCK:0]   sum_grp;
    int               grp_lsb;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        c_d        = c_q;
        g_d        = g_q;
        d_d        = d_q;
        bout_d     = bout_q;
        skip_cnt_d = skip_cnt_q;

        // Subtraction is x + ~y + carry, with carry seeded from ~bin
        grp_lsb = int'(g_q) * BLOCK;
        x_grp   = x_q[grp_lsb +: BLOCK];
        y_grp   = y_q[grp_lsb +: BLOCK];
        p_grp   = x_grp ^ ~y_grp;
        sum_grp = {1'b0, x_grp} + {1'b0, ~y_grp} + {{BLOCK{1'b0}}, c_q};

        case (state_q)
            IDLE: begin
                if (io.in_valid && in_ready_q) begin
                    x_d        = io.x;
                    y_d        = io.y;
                    c_d        = ~io.bin;
                    g_d        = '0;
                    skip_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                d_d[grp_lsb +: BLOCK] = sum_grp[BLOCK-1:0];
                // A fully propagating group passes its carry-in straight through
                c_d = (&p_grp) ? c_q : sum_grp[BLOCK];
                if (&p_grp) begin
                    skip_cnt_d = skip_cnt_q + SW'(1);
                end
                if (g_q == LAST_G) begin
                    bout_d  = ~c_d;
                    state_d = DONE;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            c_q        <= 1'b0;
            g_q        <= '0;
            d_q        <= '0;
            bout_q     <= 1'b0;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            x_q        <= x_d;
            y_q        <= y_d;
            c_q        <= c_d;
            g_q        <= g_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = (state_q == DONE);
    assign io.d         = d_q;
    assign io.bout      = bout_q;
    assign io.skip_cnt  = skip_cnt_q;
endmodule

// File: doc/carryskip_sub_seq32.md
# carryskip_sub_seq32

Iterative carry-skip subtractor for the FIR datapath study. It computes `d = x − y − bin` over one BLOCK-bit skip group per clock, using the same group-propagate skip structure as the team's 32-bit carry-skip adder, applied to `x + ~y + ~bin`. Operands enter through a valid/ready handshake and results leave through a second one. This gives the coefficient-update and error-term paths a small-area, multi-cycle subtract with borrow-out and a skip-activity count for the architectural comparison.

## Interface
- `WIDTH`, 32, operand and result width; must be an integer multiple of `BLOCK`.
- `BLOCK`, 8, skip-group width; one group is processed per RUN cycle.
- `NG`, derived as WIDTH/BLOCK (4 by default); not user-set.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `x`  in  WIDTH  minuend, unsigned.
- `y`  in  WIDTH  subtrahend, unsigned.
- `bin`  in  1  borrow in.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `d`  out  WIDTH  difference, (x − y − bin) mod 2^WIDTH.
- `bout`  out  1  borrow out: 1 iff x < y + bin (unsigned).
- `skip_cnt`  out  clog2(NG+1) (3 by default)  number of groups whose carry was skipped.

## Operation
- **States**
  - IDLE: `in_ready`=1.
  - RUN: group index `g` runs 0..NG−1.
  - DONE: `out_valid`=1.
- **Accept.** In IDLE, `in_valid`&&`in_ready` at a clock edge:
  - latch `x`, `y`, `bin`;
  - set carry c = ~bin, `g`=0, `skip_cnt`=0;
  - go to RUN.
- **Per RUN cycle, group g (bits g·BLOCK+BLOCK−1 .. g·BLOCK):**
  - p = x_g ^ ~y_g;
  - {co, s_g} = x_g + ~y_g + c;
  - write s_g into `d` bits of group g;
  - next c = (&p) ? c : co. This is the skip path and is functionally identical to co.
  - If &p, `skip_cnt` increments. &p is true exactly when x_g == y_g.
- **After group NG−1:**
  - `bout` = ~c_final;
  - go to DONE.
- **DONE.**
  - `d`, `bout` and `skip_cnt` are held stable while `out_valid`=1.
  - On `out_valid`&&`out_ready`, go to IDLE.
  - `d`, `bout` and `skip_cnt` keep their values until the next accept clears `skip_cnt`.
- **Input handling.**
  - `in_valid` is ignored outside IDLE.
  - `x`, `y` and `bin` are sampled only on the accept edge, so later input changes have no effect.
- **Reset.**
  - `rst` high at an edge forces IDLE from any state; an in-flight operation is discarded with no output.
  - Reset values: `out_valid`=0, `d`=0, `bout`=0, `skip_cnt`=0.
  - `in_ready` is 0 while `rst` is high and 1 from the first cycle after release.
- **Simultaneous events.** `rst` wins over `in_valid` and over `out_ready`.

## Timing
- **Latency.** Accept at edge T. RUN occupies the cycles after edges T..T+NG−1. `out_valid` rises after edge T+NG, which is edge T+4 by default.
- **Throughput.** Minimum 1 + NG + 1 cycles per operation (6 by default), with `out_ready` held high.
- **Registered outputs.** `in_ready` is 1 only in IDLE. `out_valid` is 1 only in DONE. Both are registered state decodes with no combinational path from `in_valid` or `out_ready`.
- **Back-to-back.** DONE→IDLE takes one edge, and a new accept is possible on the following edge.
- **Intermediate `d`.** During RUN, low groups of `d` already hold new bits while high groups hold stale bits. `d` is defined only while `out_valid`=1.

## Test plan
- **Basic subtract.** `x`=0x00000005, `y`=0x00000003, `bin`=0 → `d`=0x00000002, `bout`=0, `skip_cnt`=3. `out_valid` rises exactly 4 edges after accept.
- **Underflow wrap.** `x`=0x00000000, `y`=0x00000001, `bin`=0 → `d`=0xFFFFFFFF, `bout`=1, `skip_cnt`=3.
- **Full skip chain.**
  - `x`=`y`=0x12345678, `bin`=1 → `d`=0xFFFFFFFF, `bout`=1, `skip_cnt`=4.
  - Same operands with `bin`=0 → `d`=0, `bout`=0, `skip_cnt`=4.
- **Backpressure.**
  - Complete `x`=0xA5A5A5A5, `y`=0x5A5A5A5A, `bin`=0 with `out_ready`=0 for 10 cycles; pulse `in_valid` with other operands meanwhile.
  - Required: `d`=0x4B4B4B4B, `bout`=0 and `skip_cnt`=0 held stable; `in_ready`=0 throughout; the pulsed operands are not accepted.
  - After `out_ready`=1, IDLE on the next cycle.
- **Reset mid-RUN.**
  - Assert `rst` on the second RUN cycle → next cycle: `out_valid`=0, `d`=0, `bout`=0, `skip_cnt`=0, and `in_ready`=0 while `rst` is high.
  - After release, `in_ready`=1. A fresh `x`=100, `y`=200, `bin`=0 yields `d`=0xFFFFFF9C, `bout`=1, `skip_cnt`=3.
- **Random regression.** 10,000 random `x`/`y`/`bin` with random `in_valid`/`out_ready` throttling. Compare each result against the golden model: `d` and `bout` against {~bout, d} = {1'b1, x} − y − bin, and `skip_cnt` against the count of equal BLOCK-bit groups of `x` and `y`.
